// File: rtl/lu_seq_if.sv
// lu_seq_if: request/response valid-ready bundle for lu_seq.
// master drives the operation and out_ready; slave returns the result.
interface lu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] arg1;
    logic [WIDTH-1:0] arg2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, opcode, arg1, arg2, out_ready,
        input  in_ready, out_valid, result, zero, err
    );

    modport slave (
        input  in_valid, opcode, arg1, arg2, out_ready,
        output in_ready, out_valid, result, zero, err
    );
endinterface

// File: rtl/lu_seq.sv
// lu_seq: sequential logic unit, single-cycle logic ops plus chunked bit scans.
// Define LU_SEQ_MULTI_EN to build the multi-cycle ops (1000-1100) and BUSY.
module lu_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic   clk,
    input logic   rst_n,
    lu_seq_if.slave bus
);

    if ((WIDTH % CHUNK) != 0 || WIDTH < 8) begin : g_bad_cfg
        $error("lu_seq: WIDTH must be a multiple of CHUNK and >= 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef LU_SEQ_MULTI_EN
        BUSY = 2'd1,
`endif
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;
    logic [WIDTH-1:0] logic_res;
    logic             accept;

    assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        logic_res = '0;
        unique case (bus.opcode[2:0])
            3'b000: logic_res = bus.arg1 & bus.arg2;
            3'b001: logic_res = ~(bus.arg1 & bus.arg2);
            3'b010: logic_res = bus.arg1 | bus.arg2;
            3'b011: logic_res = ~(bus.arg1 | bus.arg2);
            3'b100: logic_res = bus.arg1 ^ bus.arg2;
            3'b101: logic_res = ~(bus.arg1 ^ bus.arg2);
            3'b110: logic_res = bus.arg1;
            3'b111: logic_res = ~bus.arg1;
        endcase
    end

`ifdef LU_SEQ_MULTI_EN
    localparam int K  = WIDTH / CHUNK;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [KW-1:0]    cnt;
    logic             found;
    logic [CHUNK-1:0] chunk;
    logic [CHUNK-1:0] rchunk;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] tz;
    logic [WIDTH-1:0] rev_arg;
    logic             is_multi;

    assign is_multi = bus.opcode[3] && (bus.opcode[2:0] <= 3'b100);

    // CLZ scans a bit-reversed copy so both counts walk upward from bit 0
    always_comb begin
        rev_arg = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_arg[i] = bus.arg1[WIDTH-1-i];
        end
    end

    always_comb begin
        chunk  = sh[CHUNK-1:0];
        pc     = '0;
        rchunk = '0;
        tz     = WIDTH'(CHUNK);
        for (int j = 0; j < CHUNK; j++) begin
            pc = pc + WIDTH'(chunk[j]);
            rchunk[CHUNK-1-j] = chunk[j];
        end
        for (int j = CHUNK - 1; j >= 0; j--) begin
            if (chunk[j]) tz = WIDTH'(j);
        end
        acc_nxt = acc;
        unique case (op_q)
            3'b000: acc_nxt = acc + pc;
            3'b001,
            3'b010: if (!found) acc_nxt = acc + tz;
            3'b011: acc_nxt = {acc[WIDTH-1:1], acc[0] ^ pc[0]};
            3'b100: acc_nxt = (acc << CHUNK) | WIDTH'(rchunk);
            default: acc_nxt = acc;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef LU_SEQ_MULTI_EN
            op_q     <= '0;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            found    <= 1'b0;
`endif
        end else if (accept) begin
            if (!bus.opcode[3]) begin
                state    <= DONE;
                result_q <= logic_res;
                zero_q   <= (logic_res == '0);
                err_q    <= 1'b0;
`ifdef LU_SEQ_MULTI_EN
            end else if (is_multi) begin
                state <= BUSY;
                op_q  <= bus.opcode[2:0];
                sh    <= (bus.opcode[2:0] == 3'b001) ? rev_arg : bus.arg1;
                acc   <= '0;
                cnt   <= '0;
                found <= 1'b0;
`endif
            end else begin
                state    <= DONE;
                result_q <= '0;
                zero_q   <= 1'b1;
                err_q    <= 1'b1;
            end
`ifdef LU_SEQ_MULTI_EN
        end else if (state == BUSY) begin
            sh    <= sh >> CHUNK;
            acc   <= acc_nxt;
            found <= found | (chunk != '0);
            if (cnt == KW'(K - 1)) begin
                state    <= DONE;
                cnt      <= '0;
                result_q <= acc_nxt;
                zero_q   <= (acc_nxt == '0);
                err_q    <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
`endif
        end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
        end
    end

endmodule
